vec_issue_ctrl: RTL and testbench

VEC_ISSUE_CTRL -- requirements
Module: vec_issue_ctrl

---
 rtl/vec_issue_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_vec_issue_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_issue_ctrl.sv
// vec_issue_ctrl: single-issue controller for a vector vand instruction.
// The FSM walks IDLE -> READ -> LOAD -> EXEC -> WB. Only one instruction is
// in flight at a time. A watchdog aborts an ALU operation that never completes.
module vec_issue_ctrl #(
   parameter int VLEN    = 128,
   parameter int TIMEOUT = 1024
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [5:0]      instr_op,
   input  logic [4:0]      instr_vd,
   input  logic [4:0]      instr_vs1,
   input  logic [4:0]      instr_vs2,
   input  logic [2:0]      instr_vsew,
   output logic [4:0]      rf_rd_addr1,
   output logic [4:0]      rf_rd_addr2,
   input  logic [VLEN-1:0] rf_rd_data1,
   input  logic [VLEN-1:0] rf_rd_data2,
   output logic            alu_run,
   output logic [5:0]      alu_opcode,
   output logic [2:0]      alu_vsew,
   output logic [VLEN-1:0] alu_vs1,
   output logic [VLEN-1:0] alu_vs2,
   input  logic [VLEN-1:0] alu_vd,
   input  logic            alu_done,
   output logic            rf_wr_en,
   output logic [4:0]      rf_wr_addr,
   output logic [VLEN-1:0] rf_wr_data,
   output logic            busy,
   output logic            err_illegal,
   output logic            err_timeout
);

   localparam logic [5:0]       OP_VAND  = 6'b001001;
   localparam logic [2:0]       SEW_MAX  = 3'b011;
   localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_LOAD,
      S_EXEC,
      S_WB
   } state_t;

   state_t            state_q, state_d;
   logic [5:0]        op_q,  op_d;
   logic [4:0]        vd_q,  vd_d;
   logic [4:0]        vs1_q, vs1_d;
   logic [4:0]        vs2_q, vs2_d;
   logic [2:0]        sew_q, sew_d;
   logic [VLEN-1:0]   opa_q, opa_d;
   logic [VLEN-1:0]   opb_q, opb_d;
   logic [VLEN-1:0]   res_q, res_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_ill_q, err_ill_d;
   logic              err_to_q,  err_to_d;
   logic              legal_in;

   // Only vand at element widths up to 64 bits is executable.
   assign legal_in = (instr_op == OP_VAND) && (instr_vsew <= SEW_MAX);

   // ALU operands, result and write port come straight from the latched
   // registers, so they hold still from EXEC entry until WB has finished.
   assign alu_opcode  = op_q;
   assign alu_vsew    = sew_q;
   assign alu_vs1     = opa_q;
   assign alu_vs2     = opb_q;
   assign rf_wr_addr  = vd_q;
   assign rf_wr_data  = res_q;
   assign err_illegal = err_ill_q;
   assign err_timeout = err_to_q;

   // State register; reset wins over everything, including a live EXEC.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, Moore outputs and next values for the datapath registers.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      vd_d        = vd_q;
      vs1_d       = vs1_q;
      vs2_d       = vs2_q;
      sew_d       = sew_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      res_d       = res_q;
      cnt_d       = cnt_q;
      err_ill_d   = 1'b0;
      err_to_d    = 1'b0;
      instr_ready = 1'b0;
      busy        = 1'b1;
      alu_run     = 1'b0;
      rf_wr_en    = 1'b0;
      rf_rd_addr1 = 5'd0;
      rf_rd_addr2 = 5'd0;
      case (state_q)
         S_IDLE: begin
            instr_ready = 1'b1;
            busy        = 1'b0;
            if (instr_valid) begin
               op_d  = instr_op;
               vd_d  = instr_vd;
               vs1_d = instr_vs1;
               vs2_d = instr_vs2;
               sew_d = instr_vsew;
               if (legal_in) begin
                  state_d = S_READ;
               end else begin
                  err_ill_d = 1'b1;
               end
            end
         end
         S_READ: begin
            rf_rd_addr1 = vs1_q;
            rf_rd_addr2 = vs2_q;
            state_d     = S_LOAD;
         end
         S_LOAD: begin
            // Read data returns one cycle after the address; the address is
            // held here so the returned data stays consistent with it.
            rf_rd_addr1 = vs1_q;
            rf_rd_addr2 = vs2_q;
            opa_d       = rf_rd_data1;
            opb_d       = rf_rd_data2;
            cnt_d       = '0;
            state_d     = S_EXEC;
         end
         S_EXEC: begin
            alu_run = 1'b1;
            // Completion is checked before the watchdog so a done arriving
            // on the last allowed cycle still retires the instruction.
            if (alu_done) begin
               res_d   = alu_vd;
               state_d = S_WB;
            end else if (cnt_q == CNT_LAST) begin
               err_to_d = 1'b1;
               state_d  = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WB: begin
            rf_wr_en = 1'b1;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Datapath and error-pulse registers, all cleared by reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         op_q      <= '0;
         vd_q      <= '0;
         vs1_q     <= '0;
         vs2_q     <= '0;
         sew_q     <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         res_q     <= '0;
         cnt_q     <= '0;
         err_ill_q <= 1'b0;
         err_to_q  <= 1'b0;
      end else begin
         op_q      <= op_d;
         vd_q      <= vd_d;
         vs1_q     <= vs1_d;
         vs2_q     <= vs2_d;
         sew_q     <= sew_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         res_q     <= res_d;
         cnt_q     <= cnt_d;
         err_ill_q <= err_ill_d;
         err_to_q  <= err_to_d;
      end
   end

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Scoreboard bench for vec_issue_ctrl: a register-file array model predicts
// each instruction's outcome at issue; a monitor checks DUT events in order.
module tb_vec_issue_ctrl;

   localparam int VLEN    = 128;
   localparam int TIMEOUT = 16;
   localparam int K_WR    = 0;
   localparam int K_ILL   = 1;
   localparam int K_TO    = 2;
   localparam logic [5:0] VAND = 6'b001001;

   typedef logic [VLEN-1:0] vec_t;

   typedef struct {
      int         kind;
      logic [4:0] vd;
      vec_t       data;
      vec_t       a;
      vec_t       b;
      logic [5:0] op;
      logic [2:0] sew;
      int         dly;
      longint     acc;
   } exp_t;

   logic       clk = 1'b0;
   logic       resetn;
   logic       instr_valid;
   logic       instr_ready;
   logic [5:0] instr_op;
   logic [4:0] instr_vd, instr_vs1, instr_vs2;
   logic [2:0] instr_vsew;
   logic [4:0] rf_rd_addr1, rf_rd_addr2;
   vec_t       rf_rd_data1, rf_rd_data2;
   logic       alu_run;
   logic [5:0] alu_opcode;
   logic [2:0] alu_vsew;
   vec_t       alu_vs1, alu_vs2, alu_vd;
   logic       alu_done;
   logic       rf_wr_en;
   logic [4:0] rf_wr_addr;
   vec_t       rf_wr_data;
   logic       busy, err_illegal, err_timeout;

   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;
   vec_t   tb_rf  [32];
   vec_t   ref_rf [32];
   logic   preload = 1'b1;
   int     cur_delay = 0;
   int     alu_cnt = 0;
   exp_t   q[$];

   always #5 clk = ~clk;

   vec_issue_ctrl #(.VLEN(VLEN), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .resetn(resetn),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_vd(instr_vd), .instr_vs1(instr_vs1),
      .instr_vs2(instr_vs2), .instr_vsew(instr_vsew),
      .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
      .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
      .alu_run(alu_run), .alu_opcode(alu_opcode), .alu_vsew(alu_vsew),
      .alu_vs1(alu_vs1), .alu_vs2(alu_vs2), .alu_vd(alu_vd), .alu_done(alu_done),
      .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
      .busy(busy), .err_illegal(err_illegal), .err_timeout(err_timeout)
   );

   task automatic chk(input string nm, input vec_t act, input vec_t exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp_v);
      end
   endtask

   function automatic vec_t rnd_vec();
      vec_t v;
      for (int i = 0; i < VLEN; i += 32) v[i +: 32] = $urandom();
      return v;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Register file: synchronous write, read data one cycle after the address.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 32; i++) tb_rf[i] <= ref_rf[i];
      end else if (rf_wr_en) begin
         tb_rf[rf_wr_addr] <= rf_wr_data;
      end
      rf_rd_data1 <= tb_rf[rf_rd_addr1];
      rf_rd_data2 <= tb_rf[rf_rd_addr2];
   end

   // ALU: done after cur_delay run cycles (never when 0); random done noise while idle.
   always @(negedge clk) begin
      if (alu_run) alu_cnt = alu_cnt + 1;
      else         alu_cnt = 0;
      if (alu_run) alu_done = (cur_delay != 0) && (alu_cnt >= cur_delay);
      else         alu_done = ($urandom_range(0, 3) == 0);
      alu_vd = (alu_run && alu_done) ? (alu_vs1 & alu_vs2) : rnd_vec();
   end

   // Monitor: pops the scoreboard on every write / error pulse.
   int   run_len = 0;
   logic prev_run = 1'b0;
   exp_t mon_e;
   int   nev, kind_act, exp_lat, exp_run;
   always @(negedge clk) begin
      if (!resetn) begin
         run_len  = 0;
         prev_run = 1'b0;
      end else begin
         if (alu_run) run_len++;
         if (alu_run && !prev_run && q.size() > 0 && q[0].kind != K_ILL) begin
            chk("alu_vs1", alu_vs1, q[0].a);
            chk("alu_vs2", alu_vs2, q[0].b);
            chk("alu_opcode", vec_t'(alu_opcode), vec_t'(q[0].op));
            chk("alu_vsew", vec_t'(alu_vsew), vec_t'(q[0].sew));
         end
         prev_run = alu_run;
         if (instr_ready || rf_wr_en) begin
            chk("rd_addr1_idle", vec_t'(rf_rd_addr1), vec_t'(0));
            chk("rd_addr2_idle", vec_t'(rf_rd_addr2), vec_t'(0));
         end
         nev = int'(rf_wr_en) + int'(err_illegal) + int'(err_timeout);
         if (nev > 1) begin
            checks++; errors++;
            $display("FAIL multi_event wr=%0b ill=%0b to=%0b required one", rf_wr_en, err_illegal, err_timeout);
         end else if (nev == 1) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_event wr=%0b ill=%0b to=%0b required none", rf_wr_en, err_illegal, err_timeout);
            end else begin
               mon_e    = q.pop_front();
               kind_act = rf_wr_en ? K_WR : (err_illegal ? K_ILL : K_TO);
               exp_lat  = (mon_e.kind == K_WR) ? mon_e.dly + 3 : (mon_e.kind == K_ILL) ? 1 : TIMEOUT + 3;
               exp_run  = (mon_e.kind == K_WR) ? mon_e.dly : (mon_e.kind == K_ILL) ? 0 : TIMEOUT;
               chk("event_kind", vec_t'(kind_act), vec_t'(mon_e.kind));
               chk("latency", vec_t'(cyc - mon_e.acc + 1), vec_t'(exp_lat));
               chk("alu_run_cycles", vec_t'(run_len), vec_t'(exp_run));
               if (rf_wr_en && mon_e.kind == K_WR) begin
                  chk("wr_addr", vec_t'(rf_wr_addr), vec_t'(mon_e.vd));
                  chk("wr_data", rf_wr_data, mon_e.data);
               end
               if (err_illegal) begin
                  chk("ready_on_illegal", vec_t'(instr_ready), vec_t'(1));
                  chk("busy_on_illegal", vec_t'(busy), vec_t'(0));
               end
               run_len = 0;
            end
         end
      end
   end

   task automatic randomize_fields();
      instr_op   = 6'($urandom_range(0, 63));
      instr_vd   = 5'($urandom_range(0, 31));
      instr_vs1  = 5'($urandom_range(0, 31));
      instr_vs2  = 5'($urandom_range(0, 31));
      instr_vsew = 3'($urandom_range(0, 7));
   endtask

   task automatic issue(input logic [5:0] op, input logic [4:0] vd, input logic [4:0] vs1,
                        input logic [4:0] vs2, input logic [2:0] sew, input int dly, input bit push);
      exp_t e;
      int   guard;
      bit   legal;
      guard = 0;
      @(negedge clk);
      while (!instr_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!instr_ready) begin
         checks++; errors++;
         $display("FAIL wait_ready actual=0 required=1");
         return;
      end
      instr_valid = 1'b1;
      instr_op    = op;
      instr_vd    = vd;
      instr_vs1   = vs1;
      instr_vs2   = vs2;
      instr_vsew  = sew;
      cur_delay   = dly;
      legal  = (op == VAND) && (sew <= 3'd3);
      e.vd   = vd;
      e.op   = op;
      e.sew  = sew;
      e.dly  = dly;
      e.a    = ref_rf[vs1];
      e.b    = ref_rf[vs2];
      e.data = ref_rf[vs1] & ref_rf[vs2];
      if (!legal)                          e.kind = K_ILL;
      else if (dly == 0 || dly > TIMEOUT)  e.kind = K_TO;
      else                                 e.kind = K_WR;
      if (push && e.kind == K_WR) ref_rf[vd] = e.data;
      @(posedge clk);
      #1;
      e.acc = cyc;
      if (push) q.push_back(e);
      instr_valid = 1'b0;
      randomize_fields();
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((q.size() != 0 || !instr_ready) && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      if (q.size() != 0 || !instr_ready) begin
         checks++; errors++;
         $display("FAIL drain pending=%0d ready=%0b required 0 and 1", q.size(), instr_ready);
      end
   endtask

   initial begin
      int r, dly;
      logic [5:0] op;
      logic [2:0] sew;
      resetn      = 1'b0;
      instr_valid = 1'b0;
      alu_done    = 1'b0;
      alu_vd      = '0;
      randomize_fields();
      for (int i = 0; i < 32; i++) ref_rf[i] = rnd_vec();
      ref_rf[1] = {16{8'hF0}};
      ref_rf[2] = {8{16'hFF00}};
      repeat (3) @(negedge clk);
      chk("rst_ready", vec_t'(instr_ready), vec_t'(1));
      chk("rst_busy", vec_t'(busy), vec_t'(0));
      chk("rst_alu_run", vec_t'(alu_run), vec_t'(0));
      chk("rst_wr_en", vec_t'(rf_wr_en), vec_t'(0));
      chk("rst_err_ill", vec_t'(err_illegal), vec_t'(0));
      chk("rst_err_to", vec_t'(err_timeout), vec_t'(0));
      chk("rst_wr_addr", vec_t'(rf_wr_addr), vec_t'(0));
      chk("rst_wr_data", rf_wr_data, vec_t'(0));
      chk("rst_alu_vs1", alu_vs1, vec_t'(0));
      chk("rst_alu_op", vec_t'(alu_opcode), vec_t'(0));
      preload = 1'b0;
      resetn  = 1'b1;

      // Directed cases.
      issue(VAND, 5'd3, 5'd1, 5'd2, 3'd0, 8, 1'b1);
      issue(6'd0, 5'd4, 5'd1, 5'd2, 3'd0, 5, 1'b1);
      issue(VAND, 5'd4, 5'd1, 5'd2, 3'b100, 5, 1'b1);
      issue(VAND, 5'd7, 5'd1, 5'd2, 3'd0, 0, 1'b1);
      issue(VAND, 5'd8, 5'd1, 5'd2, 3'b011, TIMEOUT, 1'b1);
      issue(VAND, 5'd9, 5'd3, 5'd1, 3'd2, 1, 1'b1);
      issue(VAND, 5'd5, 5'd1, 5'd3, 3'd0, 4, 1'b1);
      issue(VAND, 5'd6, 5'd5, 5'd5, 3'd1, 3, 1'b1);
      issue(VAND, 5'd5, 5'd5, 5'd2, 3'd0, 2, 1'b1);
      drain();
      chk("rf3_vand_result", tb_rf[3], {8{16'hF000}});

      // Reset while executing, then a normal instruction.
      issue(VAND, 5'd10, 5'd1, 5'd2, 3'd0, 0, 1'b0);
      repeat (4) @(negedge clk);
      chk("pre_reset_in_exec", vec_t'(alu_run), vec_t'(1));
      resetn = 1'b0;
      @(negedge clk);
      chk("mid_rst_alu_run", vec_t'(alu_run), vec_t'(0));
      chk("mid_rst_busy", vec_t'(busy), vec_t'(0));
      chk("mid_rst_wr_en", vec_t'(rf_wr_en), vec_t'(0));
      @(negedge clk);
      resetn = 1'b1;
      issue(VAND, 5'd10, 5'd1, 5'd2, 3'd0, 3, 1'b1);
      drain();
      chk("rf10_after_reset", tb_rf[10], ref_rf[10]);

      // Randomized traffic.
      for (int n = 0; n < 150; n++) begin
         op  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : VAND;
         sew = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
         r   = $urandom_range(0, 19);
         dly = (r == 0) ? 0 : $urandom_range(1, TIMEOUT);
         issue(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), sew, dly, 1'b1);
      end
      drain();
      chk("scoreboard_empty", vec_t'(q.size()), vec_t'(0));
      for (int i = 0; i < 32; i++) chk("rf_final", tb_rf[i], ref_rf[i]);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
